// File: rtl/fios_pkg.sv
// Shared types and helpers for the FIOS result collector and related word-serial blocks.
package fios_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, SUB, DONE} collector_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Word-index counter width; never zero so s==1 still gets a real register.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/fios_result_collector_if.sv
// Result-stream / modulus input and reduced-result handshake of the collector.
interface fios_result_collector_if #(
  parameter int WORD_WIDTH = 17,
  parameter int s          = 8
);
  logic                    res_valid_i;
  logic [WORD_WIDTH-1:0]   res_word_i;
  logic [s*WORD_WIDTH-1:0] p_i;
  logic [s*WORD_WIDTH-1:0] result_o;
  logic                    result_valid_o;
  logic                    result_ready_i;
  logic                    reduced_o;

  modport master (
    output res_valid_i, res_word_i, p_i, result_ready_i,
    input  result_o, result_valid_o, reduced_o
  );
  modport slave (
    input  res_valid_i, res_word_i, p_i, result_ready_i,
    output result_o, result_valid_o, reduced_o
  );
endinterface

// File: rtl/fios_word_sub.sv
// One word of a borrow-chained subtraction: {borrow_out, diff} = a - b - borrow_in.
module fios_word_sub #(
  parameter int WORD_WIDTH = 17
) (
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  input  logic                  borrow_in,
  output logic [WORD_WIDTH-1:0] diff,
  output logic                  borrow_out
);
  logic [WORD_WIDTH:0] full;

  assign full       = {1'b0, a} - {1'b0, b} - {{WORD_WIDTH{1'b0}}, borrow_in};
  assign diff       = full[WORD_WIDTH-1:0];
  assign borrow_out = full[WORD_WIDTH];
endmodule

// File: rtl/fios_result_collector.sv
// Collects the LSW-first multiplier result, applies the final conditional
// subtraction of p word-serially, and hands the reduced product out on valid/ready.
module fios_result_collector
  import fios_pkg::*;
#(
  parameter int WORD_WIDTH = 17,
  parameter int s          = 8
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  fios_result_collector_if.slave  bus,
  output logic                    busy_o,
  output logic                    overflow_o
);
  localparam int CW = cnt_width(s);
  localparam logic [CW-1:0] LAST = CW'(s - 1);

  collector_state_t state_q, state_d;
  logic [s-1:0][WORD_WIDTH-1:0] r_q, r_d, d_q, d_d, p_w;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         borrow_q, borrow_d;
  logic [s*WORD_WIDTH-1:0]      result_q, result_d;
  logic                         reduced_q, reduced_d;
  logic                         overflow_q, overflow_d;

  logic                  last, hs, accept;
  logic [WORD_WIDTH-1:0] diff;
  logic                  b_out;

  assign p_w    = bus.p_i;
  assign last   = (cnt_q == LAST);
  assign hs     = (state_q == DONE) && bus.result_ready_i;
  // A new word 0 may ride in on the very cycle the previous result is taken.
  assign accept = bus.res_valid_i && ((state_q == IDLE) || hs);

  fios_word_sub #(.WORD_WIDTH(WORD_WIDTH)) u_sub (
    .a          (r_q[cnt_q]),
    .b          (p_w[cnt_q]),
    .borrow_in  (borrow_q),
    .diff       (diff),
    .borrow_out (b_out)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      r_q        <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      borrow_q   <= 1'b0;
      result_q   <= '0;
      reduced_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      d_q        <= d_d;
      cnt_q      <= cnt_d;
      borrow_q   <= borrow_d;
      result_q   <= result_d;
      reduced_q  <= reduced_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.res_valid_i) state_d = (s == 1) ? SUB : COLLECT;
      COLLECT: if (bus.res_valid_i && last) state_d = SUB;
      SUB:     if (last) state_d = DONE;
      DONE:    if (hs) state_d = bus.res_valid_i ? ((s == 1) ? SUB : COLLECT) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r_d        = r_q;
    d_d        = d_q;
    cnt_d      = cnt_q;
    borrow_d   = borrow_q;
    result_d   = result_q;
    reduced_d  = reduced_q;
    overflow_d = overflow_q | (bus.res_valid_i &&
                 ((state_q == SUB) || ((state_q == DONE) && !bus.result_ready_i)));
    if (accept) begin
      r_d[0]   = bus.res_word_i;
      cnt_d    = (s == 1) ? '0 : CW'(1);
      borrow_d = 1'b0;
    end else if (state_q == COLLECT && bus.res_valid_i) begin
      r_d[cnt_q] = bus.res_word_i;
      cnt_d      = last ? '0 : cnt_q + CW'(1);
      borrow_d   = 1'b0;
    end else if (state_q == SUB) begin
      d_d[cnt_q] = diff;
      borrow_d   = b_out;
      cnt_d      = last ? '0 : cnt_q + CW'(1);
      // Final borrow set means R < p, so the unreduced value is already the answer.
      if (last) begin
        result_d  = b_out ? r_q : d_d;
        reduced_d = !b_out;
      end
    end
  end

  always_comb begin
    bus.result_o       = result_q;
    bus.result_valid_o = (state_q == DONE);
    bus.reduced_o      = reduced_q;
    busy_o             = (state_q != IDLE);
    overflow_o         = overflow_q;
  end

endmodule

// File: tb/tb_fios_result_collector.sv
// Scoreboard bench for fios_result_collector with s=2, WORD_WIDTH=17, p=0x20005.
module tb_fios_result_collector;
  localparam int W = 17;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst;
  logic busy, ovf;
  int   n_pass = 0;
  int   n_tot  = 0;
  logic [S*W:0] q[$];   // {reduced, result}

  fios_result_collector_if #(.WORD_WIDTH(W), .s(S)) bus ();

  fios_result_collector #(.WORD_WIDTH(W), .s(S)) dut (
    .clock_i    (clk),
    .reset_i    (rst),
    .bus        (bus),
    .busy_o     (busy),
    .overflow_o (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // Monitor: every cycle a result is presented it must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && bus.result_valid_o) begin
      if (q.size() == 0) begin
        n_tot++;
        $display("FAIL sb_unexpected: result %h with empty scoreboard", bus.result_o);
      end else begin
        chk("result", 64'(bus.result_o), 64'(q[0][S*W-1:0]));
        chk("reduced", 64'(bus.reduced_o), 64'(q[0][S*W]));
        if (bus.result_ready_i) void'(q.pop_front());
      end
    end
  end

  task automatic send(input logic [W-1:0] w);
    bus.res_valid_i = 1'b1;
    bus.res_word_i  = w;
    @(posedge clk); #1;
    bus.res_valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.result_valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_vec(input string nm, input logic [W-1:0] w0, input logic [W-1:0] w1,
                         input logic [S*W-1:0] er, input logic ered);
    int n;
    q.push_back({ered, er});
    send(w0);
    send(w1);
    wait_valid(n);
    chk({nm, "_latency"}, 64'(n), 64'd2);
    @(posedge clk); #1;
    chk({nm, "_valid_drop"}, 64'(bus.result_valid_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst                = 1'b1;
    bus.res_valid_i    = 1'b0;
    bus.res_word_i     = '0;
    bus.result_ready_i = 1'b1;
    bus.p_i            = {17'h00001, 17'h00005};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.result_valid_o), 64'd0);
    chk("rst_result", 64'(bus.result_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_vec("gt",     17'h00007, 17'h00001, 34'h00002, 1'b1);
    run_vec("lt",     17'h00003, 17'h00001, 34'h20003, 1'b0);
    run_vec("eq",     17'h00005, 17'h00001, 34'h00000, 1'b1);
    // 0x40000 - 0x20005: low word borrows (0x1FFFB), high word 2-1-1 = 0
    run_vec("borrow", 17'h00000, 17'h00002, 34'h1FFFB, 1'b1);

    // Backpressure, then word 0 of the next result on the handshake cycle
    bus.result_ready_i = 1'b0;
    q.push_back({1'b1, 34'h00002});
    send(17'h00007);
    send(17'h00001);
    wait_valid(n);
    chk("hold_latency", 64'(n), 64'd2);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_valid", 64'(bus.result_valid_o), 64'd1);
    q.push_back({1'b0, 34'h20003});
    bus.result_ready_i = 1'b1;
    send(17'h00003);
    chk("b2b_ovf", 64'(ovf), 64'd0);
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_valid", 64'(bus.result_valid_o), 64'd0);
    send(17'h00001);
    wait_valid(n);
    chk("b2b_latency", 64'(n), 64'd2);
    @(posedge clk); #1;

    // Extra word during SUB is dropped and flagged
    q.push_back({1'b1, 34'h00002});
    send(17'h00007);
    send(17'h00001);
    send(17'h1FFFF);
    chk("sub_ovf", 64'(ovf), 64'd1);
    wait_valid(n);
    chk("sub_latency", 64'(n), 64'd1);
    @(posedge clk); #1;
    chk("ovf_sticky", 64'(ovf), 64'd1);

    // Reset mid-collection
    send(17'h00003);
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_ovf", 64'(ovf), 64'd0);
    chk("mrst_result", 64'(bus.result_o), 64'd0);
    chk("mrst_reduced", 64'(bus.reduced_o), 64'd0);
    chk("mrst_valid", 64'(bus.result_valid_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec("fresh", 17'h00007, 17'h00001, 34'h00002, 1'b1);
    chk("fresh_ovf", 64'(ovf), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
